disp_min_pipe: RTL and testbench

// - Pipelined arg-min over one pixel's aggregated SGBM cost vector (DISP_RANGE lanes).
// - Returns the minimum cost and its lane index, fixed latency, one new vector accepted every clock.
// - Used twice per disparity-calc datapath: first for best match, then, with the winner lane forced
//   to all-ones, for the second-best cost in the uniqueness check.

---
 rtl/disp_min_pipe.sv | 97 +++++++++
 tb/tb_disp_min_pipe.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/disp_min_pipe.sv
// disp_min_pipe: pipelined arg-min over one pixel's aggregated cost vector.
// Returns the smallest lane cost and its lane index after a fixed LATENCY clocks.
// Throughput is one vector per clock. Ties resolve to the lowest lane index.
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   cost_aggr    DISP_RANGE packed cost lanes, lane 0 at the LSBs
//   min_cost     registered minimum cost of the vector
//   min_cost_pos registered lane index of that minimum
`timescale 1ns/1ps

module disp_min_pipe #(
    parameter int unsigned DISP_RANGE = 108,
    parameter int unsigned COST_WIDTH = 8,
    parameter int unsigned POS_WIDTH  = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DISP_RANGE*COST_WIDTH-1:0] cost_aggr,
    output logic [COST_WIDTH-1:0]            min_cost,
    output logic [POS_WIDTH-1:0]             min_cost_pos
);

    // Input register level plus one register level per reduction step.
    localparam int unsigned LATENCY = 1 + $clog2(DISP_RANGE);

    // Number of candidates held at a given register level.
    function automatic int unsigned lane_count(input int unsigned level);
        int unsigned n;
        n = DISP_RANGE;
        for (int unsigned k = 0; k < level; k++) begin
            n = (n + 1) / 2;
        end
        return n;
    endfunction

    for (genvar l = 0; l < LATENCY; l++) begin : g_lvl
        localparam int unsigned N = lane_count(l);

        logic [N*COST_WIDTH-1:0] cost_d;
        logic [N*COST_WIDTH-1:0] cost_q;
        logic [N*POS_WIDTH-1:0]  pos_d;
        logic [N*POS_WIDTH-1:0]  pos_q;

        if (l == 0) begin : g_src
            // Capture every lane together with its constant lane index.
            assign cost_d = cost_aggr;
            for (genvar j = 0; j < N; j++) begin : g_idx
                assign pos_d[j*POS_WIDTH +: POS_WIDTH] = POS_WIDTH'(j);
            end
        end else begin : g_red
            localparam int unsigned NP = lane_count(l - 1);

            for (genvar j = 0; j < N; j++) begin : g_node
                if (2*j + 1 < NP) begin : g_pair
                    logic [COST_WIDTH-1:0] a_cost;
                    logic [COST_WIDTH-1:0] b_cost;
                    logic [POS_WIDTH-1:0]  a_pos;
                    logic [POS_WIDTH-1:0]  b_pos;
                    logic                  take_b;

                    assign a_cost = g_lvl[l-1].cost_q[(2*j)*COST_WIDTH +: COST_WIDTH];
                    assign b_cost = g_lvl[l-1].cost_q[(2*j+1)*COST_WIDTH +: COST_WIDTH];
                    assign a_pos  = g_lvl[l-1].pos_q[(2*j)*POS_WIDTH +: POS_WIDTH];
                    assign b_pos  = g_lvl[l-1].pos_q[(2*j+1)*POS_WIDTH +: POS_WIDTH];

                    // Strict less-than keeps the lower-index candidate on a tie.
                    assign take_b = (b_cost < a_cost);

                    assign cost_d[j*COST_WIDTH +: COST_WIDTH] = take_b ? b_cost : a_cost;
                    assign pos_d[j*POS_WIDTH +: POS_WIDTH]    = take_b ? b_pos  : a_pos;
                end else begin : g_pass
                    // Unpaired last candidate of an odd-sized level moves up unchanged.
                    assign cost_d[j*COST_WIDTH +: COST_WIDTH] =
                        g_lvl[l-1].cost_q[(2*j)*COST_WIDTH +: COST_WIDTH];
                    assign pos_d[j*POS_WIDTH +: POS_WIDTH] =
                        g_lvl[l-1].pos_q[(2*j)*POS_WIDTH +: POS_WIDTH];
                end
            end
        end

        // Level register; reset loads the neutral candidate (max cost, lane 0).
        always_ff @(posedge clk) begin
            if (rst) begin
                cost_q <= '1;
                pos_q  <= '0;
            end else begin
                cost_q <= cost_d;
                pos_q  <= pos_d;
            end
        end
    end

    assign min_cost     = g_lvl[LATENCY-1].cost_q;
    assign min_cost_pos = g_lvl[LATENCY-1].pos_q;

endmodule

// File: tb/tb_disp_min_pipe.sv
// Self-checking bench for disp_min_pipe: directed vector table, random stream, mid-stream reset.
`timescale 1ns/1ps

module tb_disp_min_pipe;

    localparam int unsigned DR  = 108;
    localparam int unsigned CW  = 8;
    localparam int unsigned PW  = 8;
    localparam int unsigned LAT = 8;

    typedef logic [DR*CW-1:0] vec_t;
    typedef struct packed {
        logic [CW-1:0] cost;
        logic [PW-1:0] pos;
    } res_t;
    typedef struct {
        vec_t vec;
        res_t exp;
    } vect_t;

    logic          clk = 1'b0;
    logic          rst;
    vec_t          cost_aggr;
    logic [CW-1:0] min_cost;
    logic [PW-1:0] min_cost_pos;

    int   checks   = 0;
    int   failures = 0;
    res_t hist[$];
    bit   model_valid = 1'b0;

    always #5 clk = ~clk;

    disp_min_pipe #(
        .DISP_RANGE (DR),
        .COST_WIDTH (CW),
        .POS_WIDTH  (PW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cost_aggr    (cost_aggr),
        .min_cost     (min_cost),
        .min_cost_pos (min_cost_pos)
    );

    function automatic res_t reset_res();
        res_t r;
        r.cost = '1;
        r.pos  = '0;
        return r;
    endfunction

    function automatic vec_t fill(input logic [CW-1:0] c);
        vec_t v;
        for (int i = 0; i < DR; i++) v[i*CW +: CW] = c;
        return v;
    endfunction

    function automatic vec_t set_lane(input vec_t v, input int lane, input logic [CW-1:0] c);
        vec_t r;
        r = v;
        r[lane*CW +: CW] = c;
        return r;
    endfunction

    function automatic vec_t rand_vec(input int unsigned maxc);
        vec_t v;
        for (int i = 0; i < DR; i++) v[i*CW +: CW] = CW'($urandom_range(0, maxc));
        return v;
    endfunction

    // Reference: linear scan, first strictly smaller cost wins.
    function automatic res_t ref_argmin(input vec_t v);
        res_t r;
        r.cost = v[CW-1:0];
        r.pos  = '0;
        for (int i = 1; i < DR; i++) begin
            if (v[i*CW +: CW] < r.cost) begin
                r.cost = v[i*CW +: CW];
                r.pos  = PW'(i);
            end
        end
        return r;
    endfunction

    task automatic check(input string name, input res_t act, input res_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got cost=%02h pos=%0d, expected cost=%02h pos=%0d",
                     name, act.cost, act.pos, exp.cost, exp.pos);
        end
    endtask

    // Drive one vector for one edge, advance the delay-line model, compare at the falling edge.
    task automatic step(input vec_t v, input logic r);
        res_t got;
        cost_aggr = v;
        rst       = r;
        @(posedge clk);
        if (r) begin
            hist.delete();
            for (int i = 0; i < LAT; i++) hist.push_back(reset_res());
            model_valid = 1'b1;
        end
        hist.push_back(r ? reset_res() : ref_argmin(v));
        if (hist.size() > LAT) void'(hist.pop_front());
        @(negedge clk);
        got.cost = min_cost;
        got.pos  = min_cost_pos;
        if (model_valid) check("pipe_model", got, hist[0]);
    endtask

    initial begin
        vect_t tbl[7];
        res_t  got;

        tbl[0].vec = set_lane(fill(8'h40), 37, 8'h05);
        tbl[0].exp = {8'h05, 8'd37};
        tbl[1].vec = set_lane(set_lane(set_lane(fill(8'h80), 10, 8'h02), 50, 8'h02), 107, 8'h02);
        tbl[1].exp = {8'h02, 8'd10};
        tbl[2].vec = set_lane(fill(8'hFF), 0, 8'h00);
        tbl[2].exp = {8'h00, 8'd0};
        tbl[3].vec = set_lane(fill(8'hFF), 107, 8'h01);
        tbl[3].exp = {8'h01, 8'd107};
        tbl[4].vec = fill(8'hFF);
        tbl[4].exp = {8'hFF, 8'd0};
        tbl[5].vec = set_lane(fill(8'h10), 64, 8'h0F);
        tbl[5].exp = {8'h0F, 8'd64};
        tbl[6].vec = set_lane(set_lane(fill(8'h33), 54, 8'h00), 53, 8'h00);
        tbl[6].exp = {8'h00, 8'd53};

        rst       = 1'b1;
        cost_aggr = '1;
        @(negedge clk);
        step('1, 1'b1);
        step('1, 1'b1);
        got.cost = min_cost;
        got.pos  = min_cost_pos;
        check("reset_state", got, reset_res());

        // Directed table: each vector followed by all-ones fill until it emerges.
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].vec, 1'b0);
            for (int k = 0; k < LAT - 1; k++) step(fill(8'hFF), 1'b0);
            got.cost = min_cost;
            got.pos  = min_cost_pos;
            check($sformatf("table_%0d", i), got, tbl[i].exp);
        end

        // Back-to-back random stream; narrow-range vectors force many ties.
        for (int i = 0; i < 20; i++) step(rand_vec((i % 2 == 1) ? 255 : 7), 1'b0);
        for (int i = 0; i < LAT; i++) step(fill(8'hFF), 1'b0);

        // Reset mid-stream: in-flight vectors dropped, eight reset-valued outputs follow.
        for (int i = 0; i < 6; i++) step(rand_vec(63), 1'b0);
        step(rand_vec(3), 1'b1);
        got.cost = min_cost;
        got.pos  = min_cost_pos;
        check("rst_flush_0", got, reset_res());
        for (int k = 1; k < LAT; k++) begin
            step(rand_vec((k % 2 == 1) ? 3 : 255), 1'b0);
            got.cost = min_cost;
            got.pos  = min_cost_pos;
            check($sformatf("rst_flush_%0d", k), got, reset_res());
        end
        for (int i = 0; i < 12; i++) step(rand_vec(31), 1'b0);
        for (int i = 0; i < LAT; i++) step(fill(8'hFF), 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
